// File: rtl/attack_cam_pkg.sv
// Shared types and constants for the ARP-attack CAM writer.
package attack_cam_pkg;

  localparam int                   MAC_WIDTH      = 48;
  localparam logic [MAC_WIDTH-1:0] EMPTY_MAC      = '0;
  localparam int                   CAM_WR_LATENCY = 2;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    CHECK,
    EVAL,
    WRITE,
    WAIT
  } state_t;

endpackage

// File: rtl/attack_cam_writer_if.sv
// Learn-request handshake, CAM write/compare port and status of the CAM writer.
interface attack_cam_writer_if
  import attack_cam_pkg::*;
#(
  parameter int LUT_DEPTH_BITS = 4
) ();

  logic                      learn_valid;
  logic [MAC_WIDTH-1:0]      learn_mac;
  logic                      learn_ready;
  logic                      learn_done;
  logic                      learn_dup;
  logic                      learn_drop;

  logic                      cam_busy;
  logic                      cam_match;
  logic [LUT_DEPTH_BITS-1:0] cam_match_addr;
  logic [MAC_WIDTH-1:0]      cam_cmp_din;
  logic [MAC_WIDTH-1:0]      cam_din;
  logic                      cam_we;
  logic [LUT_DEPTH_BITS-1:0] cam_wr_addr;

  logic [LUT_DEPTH_BITS:0]   entry_count;
  logic                      table_full;
  logic                      init_done;

  // Writer side
  modport slave (
    input  learn_valid, learn_mac, cam_busy, cam_match, cam_match_addr,
    output learn_ready, learn_done, learn_dup, learn_drop,
           cam_cmp_din, cam_din, cam_we, cam_wr_addr,
           entry_count, table_full, init_done
  );

  // Requester / CAM side
  modport master (
    output learn_valid, learn_mac, cam_busy, cam_match, cam_match_addr,
    input  learn_ready, learn_done, learn_dup, learn_drop,
           cam_cmp_din, cam_din, cam_we, cam_wr_addr,
           entry_count, table_full, init_done
  );

endinterface

// File: rtl/attack_cam_writer.sv
// Programs trusted source MACs into the shared detection CAM with duplicate check.
// Define ATTACK_CAM_REPLACE_EN to overwrite the oldest entry when the table is full.
module attack_cam_writer
  import attack_cam_pkg::*;
#(
  parameter int LUT_DEPTH_BITS = 4,
  parameter int LUT_DEPTH      = 2**LUT_DEPTH_BITS
) (
  input  logic               clk,
  input  logic               reset,
  attack_cam_writer_if.slave bus
);

`ifdef ATTACK_CAM_REPLACE_EN
  localparam bit REPLACE_EN = 1'b1;
`else
  localparam bit REPLACE_EN = 1'b0;
`endif

  localparam logic [LUT_DEPTH_BITS:0]   FULL_COUNT = (LUT_DEPTH_BITS+1)'(LUT_DEPTH);
  localparam logic [LUT_DEPTH_BITS-1:0] LAST_ADDR  = LUT_DEPTH_BITS'(LUT_DEPTH-1);
  localparam logic [1:0]                WR_WAIT    = 2'(CAM_WR_LATENCY);

  state_t                    r_state, w_state_nxt;
  logic [MAC_WIDTH-1:0]      r_mac, w_mac_nxt;
  logic [MAC_WIDTH-1:0]      r_cmp_din, w_cmp_nxt;
  logic [MAC_WIDTH-1:0]      r_cam_din, w_din_nxt;
  logic                      r_cam_we, w_we_nxt;
  logic [LUT_DEPTH_BITS-1:0] r_cam_wr_addr, w_addr_nxt;
  logic [LUT_DEPTH_BITS-1:0] r_wr_ptr, w_ptr_nxt;
  logic [1:0]                r_wait_cnt, w_cnt_nxt;
  logic                      r_clr_wait, w_clr_wait_nxt;
  logic [LUT_DEPTH_BITS:0]   r_count, w_count_nxt;
  logic                      r_init_done, w_init_nxt;
  logic                      r_done, w_done_nxt;
  logic                      r_dup, w_dup_nxt;
  logic                      r_drop, w_drop_nxt;
  logic                      w_ready;
  logic                      w_full;
  logic                      w_unused;

  assign w_full   = (r_count == FULL_COUNT);
  // Ready is withheld in the done-pulse cycle so it always drops after an accept.
  assign w_ready  = (r_state == IDLE) && r_init_done && !r_done;
  assign w_unused = ^bus.cam_match_addr;

  always_comb begin
    w_state_nxt    = r_state;
    w_mac_nxt      = r_mac;
    w_cmp_nxt      = r_cmp_din;
    w_din_nxt      = r_cam_din;
    w_we_nxt       = 1'b0;
    w_addr_nxt     = r_cam_wr_addr;
    w_ptr_nxt      = r_wr_ptr;
    w_cnt_nxt      = r_wait_cnt;
    w_clr_wait_nxt = r_clr_wait;
    w_count_nxt    = r_count;
    w_init_nxt     = r_init_done;
    w_done_nxt     = 1'b0;
    w_dup_nxt      = 1'b0;
    w_drop_nxt     = 1'b0;
    case (r_state)
      CLEAR: begin
        if (!r_clr_wait) begin
          if (!bus.cam_busy) begin
            w_we_nxt       = 1'b1;
            w_din_nxt      = EMPTY_MAC;
            w_addr_nxt     = r_wr_ptr;
            w_cnt_nxt      = WR_WAIT;
            w_clr_wait_nxt = 1'b1;
          end
        end else if (r_wait_cnt != 2'd0) begin
          w_cnt_nxt = r_wait_cnt - 2'd1;
        end else if (!bus.cam_busy) begin
          // Pointer wraps back to 0 after the last address, ready for learning.
          w_ptr_nxt      = r_wr_ptr + LUT_DEPTH_BITS'(1);
          w_clr_wait_nxt = 1'b0;
          if (r_wr_ptr == LAST_ADDR) begin
            w_init_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      IDLE: begin
        if (bus.learn_valid && w_ready) begin
          if (bus.learn_mac == EMPTY_MAC) begin
            w_done_nxt = 1'b1;
            w_drop_nxt = 1'b1;
          end else begin
            w_mac_nxt   = bus.learn_mac;
            w_cmp_nxt   = bus.learn_mac;
            w_state_nxt = CHECK;
          end
        end
      end
      CHECK: w_state_nxt = EVAL;
      EVAL: begin
        if (bus.cam_match) begin
          w_done_nxt  = 1'b1;
          w_dup_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_full && !REPLACE_EN) begin
          w_done_nxt  = 1'b1;
          w_drop_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (!bus.cam_busy) begin
          w_we_nxt    = 1'b1;
          w_din_nxt   = r_mac;
          w_addr_nxt  = r_wr_ptr;
          w_cnt_nxt   = WR_WAIT;
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (!bus.cam_busy) begin
          w_we_nxt    = 1'b1;
          w_din_nxt   = r_mac;
          w_addr_nxt  = r_wr_ptr;
          w_cnt_nxt   = WR_WAIT;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_wait_cnt != 2'd0) begin
          w_cnt_nxt = r_wait_cnt - 2'd1;
        end else if (!bus.cam_busy) begin
          w_done_nxt  = 1'b1;
          w_ptr_nxt   = r_wr_ptr + LUT_DEPTH_BITS'(1);
          w_state_nxt = IDLE;
          if (!w_full) w_count_nxt = r_count + (LUT_DEPTH_BITS+1)'(1);
        end
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= CLEAR;
      r_mac         <= EMPTY_MAC;
      r_cmp_din     <= EMPTY_MAC;
      r_cam_din     <= EMPTY_MAC;
      r_cam_we      <= 1'b0;
      r_cam_wr_addr <= '0;
      r_wr_ptr      <= '0;
      r_wait_cnt    <= 2'd0;
      r_clr_wait    <= 1'b0;
      r_count       <= '0;
      r_init_done   <= 1'b0;
      r_done        <= 1'b0;
      r_dup         <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mac         <= w_mac_nxt;
      r_cmp_din     <= w_cmp_nxt;
      r_cam_din     <= w_din_nxt;
      r_cam_we      <= w_we_nxt;
      r_cam_wr_addr <= w_addr_nxt;
      r_wr_ptr      <= w_ptr_nxt;
      r_wait_cnt    <= w_cnt_nxt;
      r_clr_wait    <= w_clr_wait_nxt;
      r_count       <= w_count_nxt;
      r_init_done   <= w_init_nxt;
      r_done        <= w_done_nxt;
      r_dup         <= w_dup_nxt;
      r_drop        <= w_drop_nxt;
    end
  end

  assign bus.learn_ready = w_ready;
  assign bus.learn_done  = r_done;
  assign bus.learn_dup   = r_dup;
  assign bus.learn_drop  = r_drop;
  assign bus.cam_cmp_din = r_cmp_din;
  assign bus.cam_din     = r_cam_din;
  assign bus.cam_we      = r_cam_we;
  assign bus.cam_wr_addr = r_cam_wr_addr;
  assign bus.entry_count = r_count;
  assign bus.table_full  = w_full;
  assign bus.init_done   = r_init_done;

endmodule

// File: tb/tb_attack_cam_writer.sv
// Directed self-checking bench for attack_cam_writer (clear, learn, dup, drop, stall, reset).
// Expectations follow ATTACK_CAM_REPLACE_EN the same way the design does.
module tb_attack_cam_writer;
  import attack_cam_pkg::*;

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [47:0] din;
  } wr_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_err;
  int   done_n;
  int   done_cyc;
  logic done_dup;
  logic done_drop;
  wr_t  we_q[$];

  attack_cam_writer_if #(.LUT_DEPTH_BITS(4)) bus ();

  attack_cam_writer #(.LUT_DEPTH_BITS(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (bus.cam_we) begin
      e.cyc  = cyc;
      e.addr = bus.cam_wr_addr;
      e.din  = bus.cam_din;
      we_q.push_back(e);
    end
    if (bus.learn_done) begin
      done_n++;
      done_cyc  = cyc;
      done_dup  = bus.learn_dup;
      done_drop = bus.learn_drop;
      chk("dup_drop_excl", {63'd0, bus.learn_dup & bus.learn_drop}, 64'd0);
    end
  end

  task automatic learn(input logic [47:0] mac, output int acc);
    acc = -1;
    @(negedge clk);
    bus.learn_valid = 1'b1;
    bus.learn_mac   = mac;
    for (int k = 0; k < 100; k++) begin
      if (bus.learn_ready) break;
      @(negedge clk);
    end
    chk("accept", {63'd0, bus.learn_ready}, 64'd1);
    if (bus.learn_ready) acc = cyc;
    @(posedge clk);
    #1;
    bus.learn_valid = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    int k;
    k = 0;
    while (done_n == n0 && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("done_seen", {63'd0, done_n != n0}, 64'd1);
  endtask

  task automatic finish_chk(input string tag, input int acc, input int exp_lat,
                            input bit exp_dup, input bit exp_drop, input int exp_nwe,
                            input logic [3:0] exp_addr, input logic [47:0] exp_din);
    chk({tag, "_lat"}, 64'(done_cyc - acc), 64'(exp_lat));
    chk({tag, "_dup"}, {63'd0, done_dup}, {63'd0, exp_dup});
    chk({tag, "_drop"}, {63'd0, done_drop}, {63'd0, exp_drop});
    chk({tag, "_nwe"}, 64'(we_q.size()), 64'(exp_nwe));
    if (exp_nwe == 1 && we_q.size() == 1) begin
      chk({tag, "_waddr"}, {60'd0, we_q[0].addr}, {60'd0, exp_addr});
      chk({tag, "_wdin"}, {16'd0, we_q[0].din}, {16'd0, exp_din});
      chk({tag, "_wcyc"}, 64'(we_q[0].cyc - acc), 64'(exp_lat - 3));
    end
  endtask

  task automatic learn_chk(input string tag, input logic [47:0] mac, input int exp_lat,
                           input bit exp_dup, input bit exp_drop, input int exp_nwe,
                           input logic [3:0] exp_addr);
    int acc;
    int n0;
    n0 = done_n;
    we_q.delete();
    learn(mac, acc);
    wait_done(n0);
    repeat (2) @(negedge clk);
    finish_chk(tag, acc, exp_lat, exp_dup, exp_drop, exp_nwe, exp_addr, mac);
  endtask

  task automatic check_clear(input string tag);
    int k;
    k = 0;
    while (!bus.init_done && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_init_done"}, {63'd0, bus.init_done}, 64'd1);
    chk({tag, "_nwe"}, 64'(we_q.size()), 64'd16);
    for (int i = 0; i < 16 && i < we_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), {60'd0, we_q[i].addr}, 64'(i));
      chk($sformatf("%s_din%0d", tag, i), {16'd0, we_q[i].din}, 64'd0);
    end
    chk({tag, "_ready"}, {63'd0, bus.learn_ready}, 64'd1);
    chk({tag, "_count"}, {59'd0, bus.entry_count}, 64'd0);
    chk({tag, "_full"}, {63'd0, bus.table_full}, 64'd0);
    we_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, {63'd0, bus.cam_we}, 64'd0);
    chk({tag, "_done"}, {63'd0, bus.learn_done}, 64'd0);
    chk({tag, "_drop"}, {63'd0, bus.learn_drop}, 64'd0);
    chk({tag, "_ready"}, {63'd0, bus.learn_ready}, 64'd0);
    chk({tag, "_init"}, {63'd0, bus.init_done}, 64'd0);
    chk({tag, "_count"}, {59'd0, bus.entry_count}, 64'd0);
    chk({tag, "_din"}, {16'd0, bus.cam_din}, 64'd0);
    chk({tag, "_cmp"}, {16'd0, bus.cam_cmp_din}, 64'd0);
    chk({tag, "_waddr"}, {60'd0, bus.cam_wr_addr}, 64'd0);
  endtask

  localparam logic [47:0] MAC1 = 48'h00_1A_2B_3C_4D_5E;
  localparam logic [47:0] MAC2 = 48'h02_11_22_33_44_55;
  localparam logic [47:0] MAC3 = 48'h02_66_77_88_99_AA;
  localparam logic [47:0] MAC17 = 48'h0A_BB_CC_DD_EE_FF;

  initial begin
    int acc;
    int n0;
    n_chk = 0;
    n_err = 0;
    done_n = 0;
    done_cyc = 0;
    done_dup = 1'b0;
    done_drop = 1'b0;
    rst_n = 1'b0;
    bus.learn_valid    = 1'b0;
    bus.learn_mac      = '0;
    bus.cam_busy       = 1'b0;
    bus.cam_match      = 1'b0;
    bus.cam_match_addr = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    check_clear("clear");

    learn_chk("learn1", MAC1, 6, 1'b0, 1'b0, 1, 4'd0);
    chk("learn1_cmp", {16'd0, bus.cam_cmp_din}, {16'd0, MAC1});
    chk("learn1_count", {59'd0, bus.entry_count}, 64'd1);

    bus.cam_match = 1'b1;
    learn_chk("dup", MAC1, 3, 1'b1, 1'b0, 0, 4'd0);
    bus.cam_match = 1'b0;
    chk("dup_count", {59'd0, bus.entry_count}, 64'd1);

    learn_chk("zero", 48'h0, 1, 1'b0, 1'b1, 0, 4'd0);
    chk("zero_cmp_kept", {16'd0, bus.cam_cmp_din}, {16'd0, MAC1});
    chk("zero_count", {59'd0, bus.entry_count}, 64'd1);

    // Busy held for cycles a+2..a+6 pushes the write from a+3 to a+8.
    n0 = done_n;
    we_q.delete();
    learn(MAC2, acc);
    repeat (2) @(negedge clk);
    bus.cam_busy = 1'b1;
    repeat (5) @(negedge clk);
    chk("stall_no_we", 64'(we_q.size()), 64'd0);
    bus.cam_busy = 1'b0;
    wait_done(n0);
    repeat (2) @(negedge clk);
    finish_chk("stall", acc, 11, 1'b0, 1'b0, 1, 4'd1, MAC2);
    chk("stall_count", {59'd0, bus.entry_count}, 64'd2);

    n0 = done_n;
    we_q.delete();
    learn(MAC3, acc);
    repeat (4) @(negedge clk);
    chk("rstw_we_issued", 64'(we_q.size()), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstw");
    repeat (2) @(negedge clk);
    we_q.delete();
    rst_n = 1'b1;
    check_clear("reclear");
    chk("rstw_no_done", 64'(done_n - n0), 64'd0);

    for (int i = 0; i < 16; i++) begin
      logic [47:0] m;
      m = 48'h02_00_00_00_10_00 + 48'(i);
      learn_chk($sformatf("fill%0d", i), m, 6, 1'b0, 1'b0, 1, 4'(i));
    end
    chk("fill_count", {59'd0, bus.entry_count}, 64'd16);
    chk("fill_full", {63'd0, bus.table_full}, 64'd1);

`ifdef ATTACK_CAM_REPLACE_EN
    learn_chk("over", MAC17, 6, 1'b0, 1'b0, 1, 4'd0);
`else
    learn_chk("over", MAC17, 3, 1'b0, 1'b1, 0, 4'd0);
`endif
    chk("over_count", {59'd0, bus.entry_count}, 64'd16);
    chk("over_full", {63'd0, bus.table_full}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/attack_cam_writer.md
Name: attack_cam_writer

Overview:
- Write-side companion to the ARP-attack detection CAM lookup block: programs known/trusted source MACs into the 48-bit x LUT_DEPTH CAM that the detector compares against.
- Accepts learn requests over a valid/ready handshake and checks for duplicates through the CAM compare port.
- Writes new entries at a round-robin pointer, honouring the CAM's 2-cycle write latency and BUSY flag.
- Clears the whole CAM after reset.

Parameters:
LUT_DEPTH_BITS, 4, CAM address width
LUT_DEPTH, 2**LUT_DEPTH_BITS, number of CAM entries

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
learn_valid  input  1  learn request present
learn_mac  input  48  MAC to learn; held stable while learn_valid && !learn_ready
learn_ready  output  1  block can accept a request
learn_done  output  1  one-cycle pulse, request finished (any outcome)
learn_dup  output  1  one-cycle pulse with learn_done, MAC already present
learn_drop  output  1  one-cycle pulse with learn_done, request rejected
cam_busy  input  1  CAM BUSY, write in progress
cam_match  input  1  CAM MATCH, 1-cycle latency after cam_cmp_din
cam_match_addr  input  LUT_DEPTH_BITS  CAM MATCH_ADDR (debug/unused in decision)
cam_cmp_din  output  48  CAM compare data
cam_din  output  48  CAM write data
cam_we  output  1  CAM write enable, one-cycle pulse
cam_wr_addr  output  LUT_DEPTH_BITS  CAM write address
entry_count  output  LUT_DEPTH_BITS+1  valid entries, 0..LUT_DEPTH
table_full  output  1  entry_count == LUT_DEPTH
init_done  output  1  post-reset clear finished

Behaviour:
- Reset values (reset low, async): all outputs 0, cam_din/cam_cmp_din 48'h0, write pointer 0, entry_count 0, state CLEAR.
- Reset asserted mid-operation aborts any request silently (no done pulse); the clear sequence restarts on release.
- CLEAR:
  - Writes 48'h0 to addresses 0..LUT_DEPTH-1, one per iteration: cam_we for 1 cycle, then wait until cam_busy=0 (minimum 2 cycles).
  - After the last address, init_done=1 (stays 1 until reset) and the state moves to IDLE.
- IDLE:
  - learn_ready=1 only here with init_done=1.
  - On learn_valid && learn_ready: latch learn_mac, drive cam_cmp_din=learn_mac next cycle, go to CHECK.
  - learn_ready drops the cycle after acceptance.
- Zero MAC: 48'h0 is the empty marker. A request for it skips CHECK: learn_drop + learn_done pulse 1 cycle after acceptance, then IDLE.
- CHECK: one wait cycle for CAM read latency, then EVAL.
- EVAL (cam_match sampled):
  - Match: learn_dup + learn_done, no write, IDLE.
  - No match and table_full (feature off): learn_drop + learn_done, IDLE.
  - Otherwise go to WRITE.
- WRITE:
  - If cam_busy=1, stall.
  - Else drive cam_we=1, cam_din=latched MAC, cam_wr_addr=pointer for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold until cam_busy=0, checked no earlier than 2 cycles after cam_we.
  - Then pulse learn_done; pointer increments mod LUT_DEPTH (wraps 15->0 at default); entry_count increments, saturating at LUT_DEPTH; go to IDLE.
- Latency, accept to learn_done:
  - Dup/drop: 3 cycles.
  - Successful write with no BUSY stall: 6 cycles.
- Pulse rules: learn_dup and learn_drop are never both 1; each coincides with learn_done.
- Lookups by the detector may continue during learning; compare port ownership is this block's.

Optional Feature:
- Macro: ATTACK_CAM_REPLACE_EN
- Defined: when table_full, a non-duplicate MAC overwrites the entry at the round-robin pointer (oldest). entry_count stays LUT_DEPTH, the pointer advances, learn_drop is never asserted except for the zero MAC.
- Undefined: when full, the request is dropped as in EVAL.

Decomposition:
- Package attack_cam_pkg:
  - MAC_WIDTH=48
  - EMPTY_MAC=48'h0
  - CAM_WR_LATENCY=2
  - state encoding typedef: CLEAR, IDLE, CHECK, EVAL, WRITE, WAIT
- Single module; no sub-module is natural. The CAM itself stays outside, shared with the detector.

Test Plan:
- Release reset -> exactly 16 cam_we pulses with cam_din=0, addresses 0..15; then init_done=1, learn_ready=1, entry_count=0.
- Learn 48'h00_1A_2B_3C_4D_5E with no CAM match -> cam_we at addr 0 with that MAC; learn_done 6 cycles after accept; entry_count=1, learn_dup=0.
- Repeat same MAC, bench returns cam_match=1 -> learn_dup+learn_done 3 cycles after accept; no cam_we; entry_count unchanged.
- 16 distinct MACs then a 17th:
  - Feature off -> learn_drop, no write, table_full=1.
  - Feature on -> write at addr 0, count stays 16.
- Hold cam_busy=1 for 5 cycles at WRITE -> cam_we delayed until busy low; learn_done delayed accordingly.
- Assert reset during WAIT -> no learn_done; outputs at reset values; clear sequence reruns from addr 0.
- Learn 48'h0 -> learn_drop 1 cycle after accept, no compare, no write.
